// File: rtl/rsa_arith_pkg.sv
// Shared datapath constants for the RSA arithmetic blocks (multiplier and
// restoring divider). Both blocks take their default operand width and
// fixed-point format from here so that instances agree on number format.
package rsa_arith_pkg;

    // Default operand/result width in bits.
    localparam int unsigned RSA_WIDTH = 4;

    // Default number of fractional bits; 0 selects plain integer arithmetic.
    localparam int unsigned RSA_FBITS = 0;

endpackage : rsa_arith_pkg

// File: rtl/mul.sv
// Sequential unsigned shift-add multiplier with optional fixed-point scaling.
// One partial-product step per clock; the WIDTH-bit result is the truncated
// (x*y) >> FBITS, forced to 0 with ovf=1 when it does not fit.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - single-cycle request, samples x and y (restarts if already busy)
//   x, y   - unsigned multiplicand / multiplier, WIDTH bits
//   p      - product, valid while done=1
//   busy   - high while iterating
//   done   - result valid, sticky until the next start
//   ovf    - scaled product overflowed WIDTH bits (p is 0)
module mul
    import rsa_arith_pkg::*;
#(
    parameter int unsigned WIDTH = RSA_WIDTH,
    parameter int unsigned FBITS = RSA_FBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] p,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic {
        IDLE,
        CALC
    } state_e;

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [DW-1:0]    x1_q,    x1_d;
    logic [WIDTH-1:0] y1_q,    y1_d;
    logic [DW-1:0]    acc_q,   acc_d;
    logic [IW-1:0]    i_q,     i_d;
    logic [WIDTH-1:0] p_q,     p_d;
    logic             done_q,  done_d;
    logic             ovf_q,   ovf_d;

    logic [DW-1:0]    acc_next;
    logic             hi_nz;

    always_comb begin
        state_d = state_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        acc_d   = acc_q;
        i_d     = i_q;
        p_d     = p_q;
        done_d  = done_q;
        ovf_d   = ovf_q;

        acc_next = acc_q + (y1_q[0] ? x1_q : '0);
        // Any set bit above the scaled result window means the product
        // cannot be represented after dropping the FBITS fraction bits.
        hi_nz    = |acc_next[DW-1:WIDTH+FBITS];

        if (start) begin
            // Start wins over everything, including the final iteration,
            // so an aborted operation never presents its result.
            x1_d    = {{WIDTH{1'b0}}, x};
            y1_d    = y;
            acc_d   = '0;
            i_d     = '0;
            p_d     = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
            state_d = CALC;
        end else if (state_q == CALC) begin
            x1_d  = x1_q << 1;
            y1_d  = y1_q >> 1;
            acc_d = acc_next;
            i_d   = i_q + IW'(1);
            if (i_q == IW'(WIDTH - 1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (hi_nz) begin
                    ovf_d = 1'b1;
                    p_d   = '0;
                end else begin
                    p_d   = acc_next[WIDTH+FBITS-1:FBITS];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x1_q    <= '0;
            y1_q    <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            p_q     <= p_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign p    = p_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == CALC);

endmodule : mul
